// File: rtl/battery_pkg.sv
// rtl/battery_pkg.sv - shared types and defaults for battery pack control blocks
package battery_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DEAD   = 2'd2,
        ST_FAULT  = 2'd3
    } bat_state_t;

    localparam logic [1:0] CAUSE_NONE       = 2'd0;
    localparam logic [1:0] CAUSE_AUTO       = 2'd1;
    localparam logic [1:0] CAUSE_FORCE      = 2'd2;
    localparam logic [1:0] CAUSE_FAULT_EXIT = 2'd3;

    localparam logic [31:0] VMIN_DEFAULT = 32'd3000;
    localparam logic [31:0] HYST_DEFAULT = 32'd50;

endpackage

// File: rtl/battery_dwell_counter.sv
// rtl/battery_dwell_counter.sv - 8-bit counter with load, clear and conditional increment
module battery_dwell_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/battery_source_selector.sv
// rtl/battery_source_selector.sv - pack select FSM with hysteresis, dwell, dead time and UV lockout; optional BATSEL_STATUS_EN
module battery_source_selector
    import battery_pkg::*;
#(
    parameter logic [31:0] VMIN     = VMIN_DEFAULT,
    parameter logic [31:0] HYST     = HYST_DEFAULT,
    parameter int          DWELL    = 4,
    parameter int          DEAD_CYC = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] v0,
    input  logic [31:0] v1,
    input  logic        sample_valid,
    input  logic        force_en,
    input  logic        force_sel,
`ifdef BATSEL_STATUS_EN
    output logic [15:0] switch_count,
    output logic [1:0]  last_cause,
`endif
    output logic        select,
    output logic        output_en,
    output logic        switching,
    output logic        fault
);

    localparam logic [7:0] DWELL_C   = 8'(DWELL);
    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYC - 1);

    bat_state_t  state;
    logic [7:0]  cnt;
    logic        cnt_clr, cnt_inc, cnt_load;
    logic [7:0]  cnt_load_val;
    logic [31:0] v_cur, v_oth;
    logic        both_low, qualify, dwell_hit, exit_ok, exit_tgt, go_dead;

    assign v_cur     = select ? v1 : v0;
    assign v_oth     = select ? v0 : v1;
    assign both_low  = (v0 < VMIN) && (v1 < VMIN);
    // 33-bit sums so a near-full-scale reading cannot wrap past the threshold
    assign qualify   = ({1'b0, v_oth} >= ({1'b0, v_cur} + {1'b0, HYST})) && (v_oth >= VMIN);
    assign dwell_hit = ({1'b0, cnt} + 9'd1) >= {1'b0, DWELL_C};
    assign exit_ok   = ({1'b0, v0} >= ({1'b0, VMIN} + {1'b0, HYST})) ||
                       ({1'b0, v1} >= ({1'b0, VMIN} + {1'b0, HYST}));
    assign exit_tgt  = v1 > v0;

    always_comb begin
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = DEAD_LOAD;
        go_dead      = 1'b0;
        case (state)
            ST_ACTIVE: begin
                if (sample_valid) begin
                    if (both_low) begin
                        cnt_clr = 1'b1;
                    end else if (force_en) begin
                        if (force_sel != select) go_dead = 1'b1;
                        else                     cnt_clr = 1'b1;
                    end else if (qualify) begin
                        if (dwell_hit) go_dead = 1'b1;
                        else           cnt_inc = 1'b1;
                    end else begin
                        cnt_clr = 1'b1;
                    end
                end
            end
            ST_DEAD: begin
                // dead time reuses the counter as a down-counter via load
                if (cnt == 8'd0) begin
                    cnt_clr = 1'b1;
                end else begin
                    cnt_load     = 1'b1;
                    cnt_load_val = cnt - 8'd1;
                end
            end
            ST_FAULT: begin
                if (sample_valid && exit_ok) begin
                    if (exit_tgt != select) go_dead = 1'b1;
                    else                    cnt_clr = 1'b1;
                end
            end
            default: ;
        endcase
        if (go_dead) begin
            cnt_load     = 1'b1;
            cnt_load_val = DEAD_LOAD;
        end
    end

    battery_dwell_counter u_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .count    (cnt)
    );

`ifdef BATSEL_STATUS_EN
    logic [1:0] cause;
    assign cause = (state == ST_FAULT) ? CAUSE_FAULT_EXIT :
                   force_en            ? CAUSE_FORCE      : CAUSE_AUTO;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            select    <= 1'b0;
            output_en <= 1'b0;
            switching <= 1'b0;
            fault     <= 1'b0;
`ifdef BATSEL_STATUS_EN
            switch_count <= 16'd0;
            last_cause   <= CAUSE_NONE;
`endif
        end else begin
            case (state)
                ST_INIT: begin
                    if (sample_valid) begin
                        if (both_low) begin
                            state <= ST_FAULT;
                            fault <= 1'b1;
                        end else begin
                            state     <= ST_ACTIVE;
                            select    <= exit_tgt;
                            output_en <= 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (sample_valid && both_low) begin
                        state     <= ST_FAULT;
                        output_en <= 1'b0;
                        fault     <= 1'b1;
                    end
                end
                ST_DEAD: begin
                    if (cnt == 8'd0) begin
                        state     <= ST_ACTIVE;
                        output_en <= 1'b1;
                        switching <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    if (sample_valid && exit_ok) begin
                        fault <= 1'b0;
                        if (!go_dead) begin
                            state     <= ST_ACTIVE;
                            output_en <= 1'b1;
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
            // break-before-make entry overrides whatever the state branch chose
            if (go_dead) begin
                state     <= ST_DEAD;
                select    <= ~select;
                output_en <= 1'b0;
                switching <= 1'b1;
`ifdef BATSEL_STATUS_EN
                if (switch_count != 16'hFFFF) switch_count <= switch_count + 16'd1;
                last_cause <= cause;
`endif
            end
        end
    end

endmodule
